// File: rtl/fpu_pack.sv
// fpu_pack: shared floating-point types for the fpu_dsp operand/result interface.
package fpu_pack;
   localparam int BW_DATA = 32;
   localparam logic [7:0] EXP_ONES = 8'hFF;
   typedef logic [BW_DATA-1:0] real_t;
   typedef struct packed {
      real_t mul;
      real_t fma;
   } dsp_res_t;
   function automatic logic is_special(real_t x);
      return x[30:23] == EXP_ONES;
   endfunction
endpackage

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: first-word-fall-through result FIFO with occupancy count.
module fpu_res_fifo #(
   parameter int DW    = 64,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [DW-1:0]              i_data,
   input  logic                       i_pop,
   output logic [DW-1:0]              o_data,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full, do_push, do_pop;
   assign o_empty = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign o_count = cnt_q;
   // Head reads as zero while empty so stale entries never leak downstream.
   assign o_data  = o_empty ? '0 : mem_q[rd_q];
   assign do_pop  = i_pop & ~o_empty;
   assign do_push = i_push & (~full | do_pop);
   assign wr_d    = !do_push ? wr_q : (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + AW'(1);
   assign rd_d    = !do_pop  ? rd_q : (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + AW'(1);
   assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= i_data;
   end
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && full && !do_pop));
endmodule

// File: rtl/fpu_dsp_issuer.sv
// fpu_dsp_issuer: flow-controlled initiator for a fixed-latency, valid-less DSP.
// Optional FPU_ISSUER_EXC_EN adds Inf/NaN flags (o_exc) and a sticky o_exc_seen.
module fpu_dsp_issuer
   import fpu_pack::*;
#(
   parameter int DELAY      = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  real_t [2:0]                i_ops,
   output real_t [2:0]                o_dsp_bus,
   input  real_t [1:0]                i_dsp_bus,
   output logic                       o_valid,
   input  logic                       i_ready,
   output real_t [1:0]                o_res,
   output logic [$clog2(DELAY+1)-1:0] o_inflight
`ifdef FPU_ISSUER_EXC_EN
   ,
   output logic [1:0]                 o_exc,
   output logic                       o_exc_seen
`endif
);
   localparam int IW = $clog2(DELAY+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);
`ifdef FPU_ISSUER_EXC_EN
   localparam int DW = 2*BW_DATA + 2;
`else
   localparam int DW = 2*BW_DATA;
`endif
   if (DELAY < 1 || FIFO_DEPTH < DELAY + 2) begin : g_param_check
      $error("fpu_dsp_issuer: requires DELAY>=1 and FIFO_DEPTH>=DELAY+2");
   end
   real_t [2:0]      bus_q, bus_d;
   logic             issue_q, issue_d;
   logic [DELAY-1:0] vsr_q, vsr_d;
   logic             accept, push, pop, empty;
   logic [DW-1:0]    fifo_wdata, fifo_rdata;
   logic [CW-1:0]    fifo_count;
   dsp_res_t         res_in;
   assign accept  = i_valid & o_ready;
   assign bus_d   = accept ? i_ops : '0;
   assign issue_d = accept;
   assign vsr_d   = DELAY'({vsr_q, issue_q});
   // Every op already issued owns a FIFO slot; this cycle's pop is not credited back.
   assign o_ready    = ($countones(vsr_q) + int'(issue_q) + int'(fifo_count)) < FIFO_DEPTH;
   assign o_inflight = IW'($countones(vsr_q));
   assign o_dsp_bus  = bus_q;
   assign push       = vsr_q[DELAY-1];
   assign o_valid    = ~empty;
   assign pop        = o_valid & i_ready;
   assign res_in     = i_dsp_bus;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_q   <= '0;
         issue_q <= 1'b0;
         vsr_q   <= '0;
      end else begin
         bus_q   <= bus_d;
         issue_q <= issue_d;
         vsr_q   <= vsr_d;
      end
   end
`ifdef FPU_ISSUER_EXC_EN
   logic exc_seen_q, exc_seen_d;
   assign fifo_wdata = {res_in, is_special(res_in.mul), is_special(res_in.fma)};
   assign o_res      = fifo_rdata[DW-1 -: 2*BW_DATA];
   assign o_exc      = fifo_rdata[1:0];
   assign exc_seen_d = exc_seen_q | (pop & |o_exc);
   assign o_exc_seen = exc_seen_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) exc_seen_q <= 1'b0;
      else        exc_seen_q <= exc_seen_d;
   end
`else
   assign fifo_wdata = res_in;
   assign o_res      = fifo_rdata;
`endif
   fpu_res_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (push),
      .i_data  (fifo_wdata),
      .i_pop   (pop),
      .o_data  (fifo_rdata),
      .o_empty (empty),
      .o_count (fifo_count)
   );
endmodule

// File: tb/tb_fpu_dsp_issuer.sv
// tb_fpu_dsp_issuer: issuer with a behavioural DELAY-cycle DSP and an IEEE single reference model.
module tb_fpu_dsp_issuer;
   import fpu_pack::*;
   localparam int DELAY = 3;
   localparam int DEPTH = 8;
   logic        clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
   real_t [2:0] i_ops = '0;
   real_t [2:0] o_dsp_bus;
   real_t [1:0] i_dsp_bus, o_res;
   logic        o_ready, o_valid;
   logic [1:0]  o_inflight;
`ifdef FPU_ISSUER_EXC_EN
   logic [1:0]  o_exc;
   logic        o_exc_seen;
`endif
   int          checks = 0, errors = 0, cyc = 0;
   logic [63:0] exp_q[$], got_q[$];
   int          pop_cyc[$];
   logic [63:0] pipe [DELAY];

   fpu_dsp_issuer #(.DELAY(DELAY), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_ops(i_ops),
      .o_dsp_bus(o_dsp_bus), .i_dsp_bus(i_dsp_bus), .o_valid(o_valid), .i_ready(i_ready),
      .o_res(o_res), .o_inflight(o_inflight)
`ifdef FPU_ISSUER_EXC_EN
      , .o_exc(o_exc), .o_exc_seen(o_exc_seen)
`endif
   );

   always #5 clk = ~clk;

   function automatic real sp2r(logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'h00)      d = {x[31], 63'd0};
      else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'd0};
      else                        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(real r);
      logic [63:0] d;
      logic [31:0] m;
      int          e;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29] | {22'd0, |d[28:0]}};
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      if (e <= 0)   return {d[63], 31'd0};
      m = {1'b0, e[7:0], d[51:29]};
      if (d[28:0] > 29'h1000_0000 || (d[28:0] == 29'h1000_0000 && d[29])) m = m + 32'd1;
      return {d[63], m[30:0]};
   endfunction

   // {a*b, a*b+c} rounded to single precision; ops[0]=a, ops[1]=b, ops[2]=c
   function automatic logic [63:0] ref_model(logic [95:0] ops);
      real p;
      p = sp2r(ops[31:0]) * sp2r(ops[63:32]);
      return {r2sp(p), r2sp(p + sp2r(ops[95:64]))};
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
   endfunction

   always @(posedge clk) begin
      pipe[0] <= ref_model(o_dsp_bus);
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
   end
   assign i_dsp_bus = pipe[DELAY-1];

   always @(negedge clk) begin
      cyc++;
      if (rst_n === 1'b1) begin
         if (i_valid && o_ready) exp_q.push_back(ref_model(i_ops));
         if (o_valid && i_ready) begin
            got_q.push_back(o_res);
            pop_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
      pop_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      checks++; if (o_dsp_bus !== '0) begin errors++; $display("FAIL reset_bus: got %h expected 0", o_dsp_bus); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
      checks++; if (o_inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", o_inflight); end
      checks++; if (o_res !== '0) begin errors++; $display("FAIL reset_res: got %h expected 0", o_res); end
   endtask

   task automatic test_single();
      int lat, infl;
      logic [63:0] held;
      clear_q();
      i_ready = 1'b0;
      i_ops = {32'h3F80_0000, 32'h4040_0000, 32'h4000_0000};
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_ops = '0;
      checks++; if (o_dsp_bus !== {32'h3F80_0000, 32'h4040_0000, 32'h4000_0000}) begin errors++; $display("FAIL single_bus: got %h expected 3f800000_40400000_40000000", o_dsp_bus); end
      lat = 0;
      infl = -1;
      for (int k = 1; k <= 10 && !o_valid; k++) begin
         @(posedge clk); #1;
         lat = k;
         if (k == 1) begin
            checks++; if (o_dsp_bus !== '0) begin errors++; $display("FAIL single_idle_bus: got %h expected 0", o_dsp_bus); end
         end
         if (k == 2) infl = o_inflight;
      end
      checks++; if (lat != DELAY + 1 || !o_valid) begin errors++; $display("FAIL single_latency: got %0d valid=%b expected %0d", lat, o_valid, DELAY + 1); end
      checks++; if (infl != 1) begin errors++; $display("FAIL single_inflight: got %0d expected 1", infl); end
      checks++; if (o_res[1] !== 32'h40C0_0000) begin errors++; $display("FAIL single_mul: got %h expected 40c00000", o_res[1]); end
      checks++; if (o_res[0] !== 32'h40E0_0000) begin errors++; $display("FAIL single_fma: got %h expected 40e00000", o_res[0]); end
      held = o_res;
      @(posedge clk); #1;
      checks++; if (o_valid !== 1'b1 || o_res !== held) begin errors++; $display("FAIL single_hold: got valid=%b res=%h expected 1 %h", o_valid, o_res, held); end
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      checks++; if (o_valid !== 1'b0 || got_q.size() != 1) begin errors++; $display("FAIL single_pop: got valid=%b pops=%0d expected 0 1", o_valid, got_q.size()); end
   endtask

   task automatic test_stream();
      int drops, gaps;
      clear_q();
      i_ready = 1'b1;
      drops = 0;
      for (int i = 0; i < 20; i++) begin
         i_ops = {rand_fp(), rand_fp(), rand_fp()};
         i_valid = 1'b1;
         if (!o_ready) drops++;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      checks++; if (drops != 0) begin errors++; $display("FAIL stream_ready: got %0d stalls expected 0", drops); end
      checks++; if (exp_q.size() != 20) begin errors++; $display("FAIL stream_accepted: got %0d expected 20", exp_q.size()); end
      for (int k = 0; k < 40 && got_q.size() < 20; k++) @(posedge clk);
      #1;
      checks++; if (got_q.size() != 20) begin errors++; $display("FAIL stream_count: got %0d expected 20", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      gaps = 0;
      for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] != pop_cyc[i-1] + 1) gaps++;
      checks++; if (gaps != 0) begin errors++; $display("FAIL stream_rate: got %0d gaps expected 0", gaps); end
   endtask

   task automatic test_backpressure();
      clear_q();
      i_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         i_ops = {rand_fp(), rand_fp(), rand_fp()};
         i_valid = 1'b1;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      checks++; if (exp_q.size() != DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", exp_q.size(), DEPTH); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", o_ready); end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_no_pop: got %0d expected 0", got_q.size()); end
      i_ready = 1'b1;
      for (int k = 0; k < 30 && got_q.size() < DEPTH; k++) @(posedge clk);
      #1;
      checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL bp_drain: got %0d expected %0d", got_q.size(), DEPTH); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", o_ready); end
      for (int i = 0; i < 3; i++) begin
         i_ops = {rand_fp(), rand_fp(), rand_fp()};
         i_valid = 1'b1;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      for (int k = 0; k < 30 && got_q.size() < DEPTH + 3; k++) @(posedge clk);
      #1;
      checks++; if (got_q.size() != DEPTH + 3 || exp_q.size() != DEPTH + 3) begin errors++; $display("FAIL bp_total: got %0d/%0d expected %0d", got_q.size(), exp_q.size(), DEPTH + 3); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      clear_q();
      for (int k = 0; k < 20000 && exp_q.size() < 1000; k++) begin
         i_valid = 1'($urandom_range(0, 1));
         i_ready = 1'($urandom_range(0, 1));
         i_ops = {rand_fp(), rand_fp(), rand_fp()};
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 100 && got_q.size() < exp_q.size(); k++) @(posedge clk);
      #1;
      checks++; if (exp_q.size() != 1000 || got_q.size() != 1000) begin errors++; $display("FAIL rand_count: got %0d results for %0d ops expected 1000", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      i_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         i_ops = {rand_fp(), rand_fp(), rand_fp()};
         i_valid = 1'b1;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_inflight !== 2'd3 || o_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got inflight=%0d valid=%b expected 3 1", o_inflight, o_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0 || o_res !== '0) begin errors++; $display("FAIL rstmid_async: got valid=%b res=%h expected 0 0", o_valid, o_res); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_q();
      i_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_ghost: got %0d results expected 0", got_q.size()); end
      i_ops = {rand_fp(), rand_fp(), rand_fp()};
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      for (int k = 0; k < 20 && got_q.size() < 1; k++) @(posedge clk);
      #1;
      checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL rstmid_after_count: got %0d/%0d expected 1", got_q.size(), exp_q.size()); end
      else begin
         checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_after_data: got %h expected %h", got_q[0], exp_q[0]); end
      end
   endtask

`ifdef FPU_ISSUER_EXC_EN
   task automatic test_exc();
      clear_q();
      i_ready = 1'b0;
      i_ops = {32'h0000_0000, 32'h4000_0000, 32'h7F80_0000};
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      for (int k = 0; k < 10 && !o_valid; k++) begin @(posedge clk); #1; end
      checks++; if (o_exc !== 2'b11) begin errors++; $display("FAIL exc_flags: got %b expected 11", o_exc); end
      checks++; if (o_res[1] !== 32'h7F80_0000) begin errors++; $display("FAIL exc_mul: got %h expected 7f800000", o_res[1]); end
      checks++; if (o_exc_seen !== 1'b0) begin errors++; $display("FAIL exc_seen_pre: got %b expected 0", o_exc_seen); end
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      checks++; if (o_exc_seen !== 1'b1) begin errors++; $display("FAIL exc_seen_post: got %b expected 1", o_exc_seen); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_random();
      test_reset_mid();
`ifdef FPU_ISSUER_EXC_EN
      test_exc();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
